// File: rtl/riscv_if_align.sv
// RV32IC fetch stage: PC, I-cache requests, 16/32-bit parcel realignment and the IF/ID register.
// Compressed parcels leave raw in inst_ppl[15:0]; expansion happens downstream.
module riscv_if_align #(
   parameter logic [31:0] RESET_PC = 32'h0000_0000,
   parameter logic [31:0] NOP_INST = 32'h0000_0013
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        stall,
   input  logic        flush,
   input  logic        redirect_valid,
   input  logic [31:0] redirect_pc,
   output logic        icache_ren,
   output logic [29:0] icache_addr,
   input  logic [31:0] icache_rdata,
   input  logic        icache_stall,
   output logic [31:0] inst_ppl,
   output logic [31:0] pc_ppl,
   output logic        compressed_ppl
);

   typedef enum logic [1:0] {
      CASE_A,  // pc word aligned: word at pc needed
      CASE_B,  // compressed parcel already in hbuf
      CASE_C,  // 32-bit instruction straddles into next word
      CASE_D   // pc[1]=1 with empty hbuf: fill hbuf first
   } issue_case_t;

   issue_case_t cur_case;

   logic [31:0] pc_reg, pc_next;
   logic [15:0] hbuf_reg, hbuf_next;
   logic        hbuf_valid_reg, hbuf_valid_next;
   logic [31:0] whold_reg, whold_next;
   logic        whold_valid_reg, whold_valid_next;
   logic        req_out_reg, req_out_next;
   logic [29:0] req_addr_reg, req_addr_next;
   logic        discard_reg, discard_next;
   logic [31:0] inst_reg, inst_next;
   logic [31:0] pc_ppl_reg, pc_ppl_next;
   logic        comp_reg, comp_next;

   logic        need_word;
   logic [29:0] need_addr;
   logic        accept;
   logic        cache_word_ok;
   logic        have_word;
   logic [31:0] word;

   always_comb begin
      if (!pc_reg[1])
         cur_case = CASE_A;
      else if (!hbuf_valid_reg)
         cur_case = CASE_D;
      else if (hbuf_reg[1:0] == 2'b11)
         cur_case = CASE_C;
      else
         cur_case = CASE_B;
   end

   assign need_word   = (cur_case != CASE_B);
   assign need_addr   = (cur_case == CASE_C) ? pc_reg[31:2] + 30'd1 : pc_reg[31:2];
   // An outstanding request keeps ren/addr frozen whatever stall or redirect do.
   assign icache_ren  = rst_n && (req_out_reg || (need_word && !whold_valid_reg && !stall));
   assign icache_addr = req_out_reg ? req_addr_reg : need_addr;
   assign accept        = icache_ren && !icache_stall;
   assign cache_word_ok = accept && !discard_reg;
   assign have_word     = whold_valid_reg || cache_word_ok;
   assign word          = whold_valid_reg ? whold_reg : icache_rdata;

   always_comb begin
      pc_next          = pc_reg;
      hbuf_next        = hbuf_reg;
      hbuf_valid_next  = hbuf_valid_reg;
      whold_next       = whold_reg;
      whold_valid_next = whold_valid_reg;
      req_out_next     = icache_ren && icache_stall;
      req_addr_next    = icache_addr;
      discard_next     = (icache_ren && icache_stall) && (discard_reg || redirect_valid);
      inst_next        = inst_reg;
      pc_ppl_next      = pc_ppl_reg;
      comp_next        = comp_reg;

      if (redirect_valid) begin
         pc_next          = {redirect_pc[31:1], 1'b0};
         hbuf_valid_next  = 1'b0;
         whold_valid_next = 1'b0;
         if (!stall) begin
            inst_next   = NOP_INST;
            pc_ppl_next = pc_reg;
            comp_next   = 1'b0;
         end
      end else if (stall || flush) begin
         // Keep any word that arrives so it is not fetched again.
         if (cache_word_ok) begin
            whold_next       = icache_rdata;
            whold_valid_next = 1'b1;
         end
         if (!stall) begin
            inst_next   = NOP_INST;
            pc_ppl_next = pc_reg;
            comp_next   = 1'b0;
         end
      end else begin
         inst_next   = NOP_INST;
         pc_ppl_next = pc_reg;
         comp_next   = 1'b0;
         case (cur_case)
            CASE_A: if (have_word) begin
               whold_valid_next = 1'b0;
               if (word[1:0] != 2'b11) begin
                  inst_next       = {16'h0000, word[15:0]};
                  comp_next       = 1'b1;
                  hbuf_next       = word[31:16];
                  hbuf_valid_next = 1'b1;
                  pc_next         = pc_reg + 32'd2;
               end else begin
                  inst_next       = word;
                  hbuf_valid_next = 1'b0;
                  pc_next         = pc_reg + 32'd4;
               end
            end
            CASE_B: begin
               inst_next       = {16'h0000, hbuf_reg};
               comp_next       = 1'b1;
               hbuf_valid_next = 1'b0;
               pc_next         = pc_reg + 32'd2;
            end
            CASE_C: if (have_word) begin
               whold_valid_next = 1'b0;
               inst_next        = {word[15:0], hbuf_reg};
               hbuf_next        = word[31:16];
               hbuf_valid_next  = 1'b1;
               pc_next          = pc_reg + 32'd4;
            end
            default: if (have_word) begin
               whold_valid_next = 1'b0;
               hbuf_next        = word[31:16];
               hbuf_valid_next  = 1'b1;
            end
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         pc_reg          <= RESET_PC;
         hbuf_reg        <= 16'h0000;
         hbuf_valid_reg  <= 1'b0;
         whold_reg       <= 32'h0000_0000;
         whold_valid_reg <= 1'b0;
         req_out_reg     <= 1'b0;
         req_addr_reg    <= 30'h0;
         discard_reg     <= 1'b0;
         inst_reg        <= NOP_INST;
         pc_ppl_reg      <= 32'h0000_0000;
         comp_reg        <= 1'b0;
      end else begin
         pc_reg          <= pc_next;
         hbuf_reg        <= hbuf_next;
         hbuf_valid_reg  <= hbuf_valid_next;
         whold_reg       <= whold_next;
         whold_valid_reg <= whold_valid_next;
         req_out_reg     <= req_out_next;
         req_addr_reg    <= req_addr_next;
         discard_reg     <= discard_next;
         inst_reg        <= inst_next;
         pc_ppl_reg      <= pc_ppl_next;
         comp_reg        <= comp_next;
      end
   end

   assign inst_ppl       = inst_reg;
   assign pc_ppl         = pc_ppl_reg;
   assign compressed_ppl = comp_reg;

endmodule

// File: tb/tb_riscv_if_align.sv
// Directed bench for riscv_if_align: stimulus queues expected IF/ID contents per cycle,
// a negedge monitor pops and compares them; a combinational memory models the I-cache.
module tb_riscv_if_align;

   localparam logic [31:0] NOP = 32'h0000_0013;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        stall = 1'b0;
   logic        flush = 1'b0;
   logic        redirect_valid = 1'b0;
   logic [31:0] redirect_pc = 32'h0;
   logic        icache_ren;
   logic [29:0] icache_addr;
   logic [31:0] icache_rdata;
   logic        icache_stall = 1'b0;
   logic [31:0] inst_ppl;
   logic [31:0] pc_ppl;
   logic        compressed_ppl;

   logic [31:0] mem [128];
   assign icache_rdata = mem[icache_addr[6:0]];

   riscv_if_align dut (
      .clk            (clk),
      .rst_n          (rst_n),
      .stall          (stall),
      .flush          (flush),
      .redirect_valid (redirect_valid),
      .redirect_pc    (redirect_pc),
      .icache_ren     (icache_ren),
      .icache_addr    (icache_addr),
      .icache_rdata   (icache_rdata),
      .icache_stall   (icache_stall),
      .inst_ppl       (inst_ppl),
      .pc_ppl         (pc_ppl),
      .compressed_ppl (compressed_ppl)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [31:0] inst;
      logic [31:0] pc;
      logic        c;
      int          cyc;
   } exp_t;

   exp_t exp_q[$];
   int   cycle_cnt = 0;
   int   errors = 0;
   int   checks = 0;

   always @(posedge clk) cycle_cnt <= cycle_cnt + 1;

   // Monitor: the IF/ID register presents a value every cycle; compare the one queued for it.
   always @(negedge clk) begin
      exp_t e;
      if (exp_q.size() > 0 && exp_q[0].cyc <= cycle_cnt) begin
         e = exp_q.pop_front();
         checks++;
         if (inst_ppl !== e.inst || pc_ppl !== e.pc || compressed_ppl !== e.c) begin
            errors++;
            $display("FAIL ifid cyc=%0d got inst=%h pc=%h c=%b want inst=%h pc=%h c=%b",
                     cycle_cnt, inst_ppl, pc_ppl, compressed_ppl, e.inst, e.pc, e.c);
         end else
            $display("ok   ifid cyc=%0d inst=%h pc=%h c=%b", cycle_cnt, inst_ppl, pc_ppl, compressed_ppl);
      end
   end

   task automatic expect_cyc(input logic [31:0] i, input logic [31:0] p, input logic c);
      exp_t e;
      e.inst = i;
      e.pc   = p;
      e.c    = c;
      e.cyc  = cycle_cnt + 1;
      exp_q.push_back(e);
      @(posedge clk);
      @(negedge clk);
   endtask

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] want);
      checks++;
      if (act !== want) begin
         errors++;
         $display("FAIL %s got=%h want=%h", name, act, want);
      end else
         $display("ok   %s = %h", name, act);
   endtask

   task automatic do_reset();
      stall = 1'b0; flush = 1'b0; redirect_valid = 1'b0; icache_stall = 1'b0;
      rst_n = 1'b0;
      #1 chk("ren_in_reset", {31'h0, icache_ren}, 32'h0);
      expect_cyc(NOP, 32'h0, 1'b0);
      rst_n = 1'b1;
   endtask

   initial begin
      for (int k = 0; k < 128; k++) mem[k] = 32'h0;
      @(negedge clk);

      // 1: plain 32-bit fetch after reset
      mem[0] = 32'h00A0_0093; mem[1] = 32'h0010_0113;
      do_reset();
      expect_cyc(32'h00A0_0093, 32'h0, 1'b0);
      expect_cyc(32'h0010_0113, 32'h4, 1'b0);

      // 2: two compressed parcels in one word, second needs no fetch
      mem[0] = 32'h0001_4505; mem[1] = 32'h00A0_0093;
      do_reset();
      expect_cyc(32'h0000_4505, 32'h0, 1'b1);
      #1 chk("ren_case_b", {31'h0, icache_ren}, 32'h0);
      expect_cyc(32'h0000_0001, 32'h2, 1'b1);
      expect_cyc(32'h00A0_0093, 32'h4, 1'b0);

      // 3: 32-bit instruction straddling words 0 and 1
      mem[0] = 32'h0093_4505; mem[1] = 32'h0000_00A0;
      do_reset();
      expect_cyc(32'h0000_4505, 32'h0, 1'b1);
      #1 chk("addr_straddle", {2'b00, icache_addr}, 32'h1);
      expect_cyc(32'h00A0_0093, 32'h2, 1'b0);
      expect_cyc(32'h0000_0000, 32'h6, 1'b1);

      // 4: redirect during a stalled cache request
      mem[0] = 32'h00A0_0093; mem[1] = 32'h0010_0113; mem[2] = 32'h0020_0193; mem[16] = 32'h0030_0213;
      do_reset();
      expect_cyc(32'h00A0_0093, 32'h0, 1'b0);
      expect_cyc(32'h0010_0113, 32'h4, 1'b0);
      icache_stall = 1'b1;
      #1 chk("ren_stall_req", {31'h0, icache_ren}, 32'h1);
      expect_cyc(NOP, 32'h8, 1'b0);
      redirect_valid = 1'b1; redirect_pc = 32'h0000_0040;
      #1 chk("addr_held_redir", {2'b00, icache_addr}, 32'h2);
      expect_cyc(NOP, 32'h8, 1'b0);
      redirect_valid = 1'b0;
      for (int k = 0; k < 3; k++) begin
         #1 chk("addr_held", {2'b00, icache_addr}, 32'h2);
         expect_cyc(NOP, 32'h40, 1'b0);
      end
      icache_stall = 1'b0;
      #1 chk("ren_drop_cycle", {31'h0, icache_ren}, 32'h1);
      expect_cyc(NOP, 32'h40, 1'b0);
      #1 chk("addr_after_redir", {2'b00, icache_addr}, 32'h10);
      expect_cyc(32'h0030_0213, 32'h40, 1'b0);

      // 5: pipeline stall while the cache returns a word, then flush
      do_reset();
      expect_cyc(32'h00A0_0093, 32'h0, 1'b0);
      icache_stall = 1'b1;
      #1 chk("ren_word1", {31'h0, icache_ren}, 32'h1);
      expect_cyc(NOP, 32'h4, 1'b0);
      stall = 1'b1;
      expect_cyc(NOP, 32'h4, 1'b0);
      icache_stall = 1'b0;
      #1 chk("ren_outstanding", {31'h0, icache_ren}, 32'h1);
      expect_cyc(NOP, 32'h4, 1'b0);
      #1 chk("ren_no_refetch", {31'h0, icache_ren}, 32'h0);
      expect_cyc(NOP, 32'h4, 1'b0);
      stall = 1'b0;
      #1 chk("ren_from_hold", {31'h0, icache_ren}, 32'h0);
      expect_cyc(32'h0010_0113, 32'h4, 1'b0);
      flush = 1'b1;
      expect_cyc(NOP, 32'h8, 1'b0);
      flush = 1'b0;
      #1 chk("ren_after_flush", {31'h0, icache_ren}, 32'h0);
      expect_cyc(32'h0020_0193, 32'h8, 1'b0);

      // 6: redirect to an odd halfword, then wrap at the top of memory
      mem[64] = 32'h4505_0001; mem[65] = 32'h00A0_0093; mem[127] = 32'h0001_0000;
      do_reset();
      expect_cyc(32'h00A0_0093, 32'h0, 1'b0);
      redirect_valid = 1'b1; redirect_pc = 32'h0000_0103;
      expect_cyc(NOP, 32'h4, 1'b0);
      redirect_valid = 1'b0;
      #1 chk("addr_case_d", {2'b00, icache_addr}, 32'h40);
      expect_cyc(NOP, 32'h102, 1'b0);
      expect_cyc(32'h0000_4505, 32'h102, 1'b1);
      expect_cyc(32'h00A0_0093, 32'h104, 1'b0);
      redirect_valid = 1'b1; redirect_pc = 32'hFFFF_FFFE;
      expect_cyc(NOP, 32'h108, 1'b0);
      redirect_valid = 1'b0;
      expect_cyc(NOP, 32'hFFFF_FFFE, 1'b0);
      expect_cyc(32'h0000_0001, 32'hFFFF_FFFE, 1'b1);
      expect_cyc(32'h00A0_0093, 32'h0, 1'b0);

      repeat (2) @(negedge clk);
      if (exp_q.size() != 0) begin
         checks++;
         errors++;
         $display("FAIL scoreboard_drain left=%0d want=0", exp_q.size());
      end
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
